ifetch_stage: RTL and testbench
===============================

Name: ifetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of the hazard unit and decode. Consumes the hazard unit's PCWrite, IFWrite and addrSel, plus a branch target from EX. Holds the PC, selects the next PC, drives the instruction-memory address and registers the fetched instruction for decode. Handles a not-ready instruction memory by holding the PC and emitting bubbles.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on bubble or flush

Ports:
CLK  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous reset, active-high
PCWrite  input  1  hazard unit: 1 = PC may update this cycle
IFWrite  input  1  hazard unit: 1 = IF/ID may load this cycle
addrSel  input  2  hazard unit next-PC select: 00 PC+4, 01 jump, 10 branch, 11 hold
BranchTarget  input  32  branch target address from EX
Flush  input  1  force a NOP into IF/ID this cycle
IMemData  input  32  instruction word at IMemAddr, valid when IMemReady=1
IMemReady  input  1  instruction memory has valid data this cycle
IMemAddr  output  32  instruction fetch address, combinational = PC
PC  output  32  current PC register
InstrID  output  32  IF/ID instruction register
PCPlus4ID  output  32  IF/ID PC+4 register
ValidID  output  1  IF/ID holds a real instruction
FetchStall  output  1  combinational = !IMemReady

Behaviour:
- Reset (Reset=1 at a rising edge, at any time, including mid-stall or mid-redirect): PC=RESET_PC, InstrID=NOP_INSTR, PCPlus4ID=0, ValidID=0. Any pending redirect is discarded.
- PCPlus4 = PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Next-PC mux (combinational):
  - 00 -> PCPlus4
  - 01 -> {PCPlus4ID[31:28], InstrID[25:0], 2'b00}, the jump target taken from the instruction in decode
  - 10 -> BranchTarget
  - 11 -> PC (hold)
- PC update at the rising edge when PCWrite=1 and (IMemReady=1 or addrSel!=00).
  - A redirect (01/10) is always taken, even with memory not ready; the stale fetch is abandoned.
  - PCWrite=0 holds the PC regardless of addrSel. Preserving the redirect is the hazard unit's responsibility.
- IF/ID update at the rising edge, priority order:
  1. Flush=1 -> InstrID=NOP_INSTR, ValidID=0, PCPlus4ID=PCPlus4. Applies even when IFWrite=0.
  2. IFWrite=0 -> all IF/ID registers hold.
  3. IMemReady=0 -> InstrID=NOP_INSTR, ValidID=0, PCPlus4ID holds.
  4. Otherwise -> InstrID=IMemData, PCPlus4ID=PCPlus4, ValidID=1.
- Latency: an instruction at address A appears on InstrID one cycle after PC=A with IMemReady=1 and IFWrite=1.
- Jump-target computation uses the registered InstrID/PCPlus4ID, not IMemData. No combinational path from IMemData to IMemAddr.
- Stall semantics: PCWrite=0 and IFWrite=0 together freeze the stage completely. PCWrite=1 and IFWrite=0 (hazard jump case) advances the PC while decode holds.

Optional Feature:
IF_PERF_CNT_EN. When defined, two extra outputs are added:
- FetchCount (32): +1 on each IF/ID load with ValidID<=1.
- StallCount (32): +1 on each cycle the PC does not update.
- Both counters reset to 0 on Reset and wrap at 2^32.

When undefined, these ports and their counters are absent and the stage behaves identically otherwise.

Test Plan:
- Reset=1 for 2 cycles, then PCWrite=IFWrite=1, addrSel=00, IMemReady=1, IMemData=32'h2008_0005 -> PC sequence 0,4,8. One cycle after PC=0: InstrID=32'h2008_0005, PCPlus4ID=4, ValidID=1.
- Jump redirect: InstrID=32'h0800_0040, PCPlus4ID=32'h0000_0010, addrSel=01 -> next PC=32'h0000_0100.
- Branch redirect: addrSel=10, BranchTarget=32'h0000_0200, PCWrite=1 -> next PC=32'h0000_0200. Same stimulus with PCWrite=0 -> PC unchanged.
- IMemReady=0 for 3 cycles at PC=32'h20 with IFWrite=1 -> PC stays 32'h20, ValidID=0, InstrID=NOP_INSTR, FetchStall=1. After ready returns, the instruction at 32'h20 enters IF/ID.
- Flush=1 with IFWrite=0 -> InstrID=0, ValidID=0 next cycle. PC=32'hFFFF_FFFC with addrSel=00 -> PC wraps to 0.
- Reset asserted mid-stall (IMemReady=0, PC=32'h40) -> next cycle PC=RESET_PC, ValidID=0. With IF_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/ifetch_stage.sv
// ifetch_stage: MIPS fetch stage with PC, next-PC mux and IF/ID register; IF_PERF_CNT_EN adds fetch/stall counters.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        IFWrite,
  input  logic [1:0]  addrSel,
  input  logic [31:0] BranchTarget,
  input  logic        Flush,
  input  logic [31:0] IMemData,
  input  logic        IMemReady,
  output logic [31:0] IMemAddr,
  output logic [31:0] PC,
  output logic [31:0] InstrID,
  output logic [31:0] PCPlus4ID,
  output logic        ValidID,
  output logic        FetchStall
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);
  logic [31:0] pc_plus4, next_pc;
  logic        pc_we, id_load;
  assign IMemAddr   = PC;
  assign FetchStall = !IMemReady;
  assign pc_plus4   = PC + 32'd4;
  // Redirects abandon a pending fetch; sequential advance waits for memory.
  assign pc_we   = PCWrite && (IMemReady || addrSel != 2'b00);
  assign id_load = !Flush && IFWrite && IMemReady;
  always_comb
    next_pc = addrSel == 2'b00 ? pc_plus4 :
              addrSel == 2'b01 ? {PCPlus4ID[31:28], InstrID[25:0], 2'b00} :
              addrSel == 2'b10 ? BranchTarget : PC;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      PC        <= RESET_PC;
      InstrID   <= NOP_INSTR;
      PCPlus4ID <= 32'd0;
      ValidID   <= 1'b0;
    end else begin
      if (pc_we) PC <= next_pc;
      if (Flush) begin
        InstrID   <= NOP_INSTR;
        ValidID   <= 1'b0;
        PCPlus4ID <= pc_plus4;
      end else if (IFWrite) begin
        InstrID <= IMemReady ? IMemData : NOP_INSTR;
        ValidID <= IMemReady;
        if (IMemReady) PCPlus4ID <= pc_plus4;
      end
    end
  end
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      FetchCount <= 32'd0;
      StallCount <= 32'd0;
    end else begin
      if (id_load) FetchCount <= FetchCount + 32'd1;
      if (!pc_we) StallCount <= StallCount + 32'd1;
    end
  end
`else
  logic unused_id_load;
  assign unused_id_load = id_load;
`endif
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: scoreboard bench for ifetch_stage using hand-computed directed vectors.
module tb_ifetch_stage;
  logic        CLK = 0, Reset, PCWrite, IFWrite, Flush, IMemReady;
  logic [1:0]  addrSel;
  logic [31:0] BranchTarget, IMemData;
  logic [31:0] IMemAddr, PC, InstrID, PCPlus4ID;
  logic        ValidID, FetchStall;
`ifdef IF_PERF_CNT_EN
  logic [31:0] FetchCount, StallCount;
`endif
  int checks = 0, errors = 0;

  typedef struct {
    string       name;
    logic [31:0] pc, instr, p4;
    logic        v, st;
  } exp_t;
  exp_t q[$];

  ifetch_stage dut (
    .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .IFWrite(IFWrite), .addrSel(addrSel),
    .BranchTarget(BranchTarget), .Flush(Flush), .IMemData(IMemData), .IMemReady(IMemReady),
    .IMemAddr(IMemAddr), .PC(PC), .InstrID(InstrID), .PCPlus4ID(PCPlus4ID),
    .ValidID(ValidID), .FetchStall(FetchStall)
`ifdef IF_PERF_CNT_EN
    , .FetchCount(FetchCount), .StallCount(StallCount)
`endif
  );

  always #5 CLK = ~CLK;

  // Monitor: after each edge, compare DUT state against the oldest expectation.
  always begin
    @(posedge CLK);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (PC !== e.pc || IMemAddr !== e.pc || InstrID !== e.instr || PCPlus4ID !== e.p4 ||
          ValidID !== e.v || FetchStall !== e.st) begin
        errors++;
        $display("FAIL %s: got pc=%h addr=%h instr=%h p4=%h v=%b st=%b, want pc=%h instr=%h p4=%h v=%b st=%b",
                 e.name, PC, IMemAddr, InstrID, PCPlus4ID, ValidID, FetchStall,
                 e.pc, e.instr, e.p4, e.v, e.st);
      end
    end
  end

  task automatic step(input string n, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] p4, input logic v, input logic st);
    exp_t e;
    e.name = n; e.pc = pc; e.instr = instr; e.p4 = p4; e.v = v; e.st = st;
    q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    Reset = 1; PCWrite = 1; IFWrite = 1; addrSel = 2'b00; BranchTarget = 0;
    Flush = 0; IMemReady = 1; IMemData = 32'h2008_0005;
    step("reset1", 32'h0, 32'h0, 32'h0, 0, 0);
    step("reset2", 32'h0, 32'h0, 32'h0, 0, 0);
`ifdef IF_PERF_CNT_EN
    checks++;
    if (FetchCount !== 0 || StallCount !== 0) begin
      errors++;
      $display("FAIL cnt_reset: got fetch=%0d stall=%0d, want 0 0", FetchCount, StallCount);
    end
`endif
    Reset = 0;
    step("seq_pc4", 32'h4, 32'h2008_0005, 32'h4, 1, 0);
    step("seq_pc8", 32'h8, 32'h2008_0005, 32'h8, 1, 0);
    IMemData = 32'h0800_0040;
    step("load_j1", 32'hC, 32'h0800_0040, 32'hC, 1, 0);
    step("load_j2", 32'h10, 32'h0800_0040, 32'h10, 1, 0);
    addrSel = 2'b01;
    step("jump", 32'h100, 32'h0800_0040, 32'h14, 1, 0);
    addrSel = 2'b10; BranchTarget = 32'h200; IMemData = 32'h1111_1111;
    step("branch", 32'h200, 32'h1111_1111, 32'h104, 1, 0);
    PCWrite = 0; IFWrite = 0;
    step("branch_nopcw", 32'h200, 32'h1111_1111, 32'h104, 1, 0);
    PCWrite = 1; IFWrite = 1; BranchTarget = 32'h20; IMemData = 32'h2222_2222;
    step("to_20", 32'h20, 32'h2222_2222, 32'h204, 1, 0);
    addrSel = 2'b00; IMemReady = 0; IMemData = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) step("mem_wait", 32'h20, 32'h0, 32'h204, 0, 1);
    IMemReady = 1; IMemData = 32'h3333_3333;
    step("mem_ready", 32'h24, 32'h3333_3333, 32'h24, 1, 0);
    Flush = 1; IFWrite = 0; PCWrite = 0;
    step("flush", 32'h24, 32'h0, 32'h28, 0, 0);
    Flush = 0; IFWrite = 1; PCWrite = 1; addrSel = 2'b10;
    BranchTarget = 32'hFFFF_FFFC; IMemData = 32'h4444_4444;
    step("to_top", 32'hFFFF_FFFC, 32'h4444_4444, 32'h28, 1, 0);
    addrSel = 2'b00; IMemData = 32'h5555_5555;
    step("wrap", 32'h0, 32'h5555_5555, 32'h0, 1, 0);
    addrSel = 2'b10; BranchTarget = 32'h40; IMemReady = 0;
    step("redir_notready", 32'h40, 32'h0, 32'h0, 0, 1);
    addrSel = 2'b11; IMemReady = 1; IMemData = 32'h6666_6666;
    step("hold11", 32'h40, 32'h6666_6666, 32'h44, 1, 0);
    addrSel = 2'b01; IMemReady = 0;
    step("jump_notready", 32'h0999_9998, 32'h0, 32'h44, 0, 1);
    addrSel = 2'b10; BranchTarget = 32'h40;
    step("stall_at_40", 32'h40, 32'h0, 32'h44, 0, 1);
    addrSel = 2'b00; Reset = 1;
    step("reset_midstall", 32'h0, 32'h0, 32'h0, 0, 1);
`ifdef IF_PERF_CNT_EN
    checks++;
    if (FetchCount !== 0 || StallCount !== 0) begin
      errors++;
      $display("FAIL cnt_midstall: got fetch=%0d stall=%0d, want 0 0", FetchCount, StallCount);
    end
`endif
    Reset = 0; IMemReady = 1; IMemData = 32'h7777_7777;
    step("after_reset", 32'h4, 32'h7777_7777, 32'h4, 1, 0);
    IFWrite = 0; IMemData = 32'h8888_8888;
    step("pc_only", 32'h8, 32'h7777_7777, 32'h4, 1, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    #3;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
